seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multi-cycle successor to the processor's combinational ALU. It adds registered carry/borrow flags, barrel shifts by a variable amount, and iterative unsigned multiply and divide, all behind a start/busy/done handshake. It sits in the execute stage. The decoder issues one operation per `start_pi`, and the stage stalls while `busy_po` is high.

## Interface
- `WIDTH`, 16, operand/result width (≥4, power of two)
- `IMM_W`, 6, immediate width (< WIDTH), zero-extended
- `clk_pi`  in  1  clock; all state changes on rising edge
- `rst_n_pi`  in  1  synchronous, active-low reset
- `start_pi`  in  1  issue op; accepted only when `busy_po`=0
- `op_pi`  in  4  opcode (see Operation)
- `a_pi`  in  WIDTH  operand 1
- `b_pi`  in  WIDTH  operand 2 (shift amount = `b_pi[$clog2(WIDTH)-1:0]`)
- `imm_pi`  in  IMM_W  immediate for ADDI/SUBI
- `stc_pi`  in  1  set carry flag
- `stb_pi`  in  1  set borrow flag
- `busy_po`  out  1  iterative op in progress
- `done_po`  out  1  one-cycle pulse; results valid
- `result_po`  out  WIDTH  result / product low / quotient
- `result_hi_po`  out  WIDTH  product high / remainder; 0 for other ops
- `carry_po`  out  1  registered carry flag
- `borrow_po`  out  1  registered borrow flag
- `div_by_zero_po`  out  1  last completed op was DIV with b=0

## Operation
- Opcodes:
  - 0 ADD, 1 ADDC (+carry), 2 SUB, 3 SUBB (−borrow)
  - 4 AND, 5 OR, 6 XOR, 7 XNOR
  - 8 NOT a, 9 SHL, 10 SHR (logical), 11 CP (a)
  - 12 ADDI (a+imm), 13 SUBI (a−imm)
  - 14 MUL (unsigned, 2·WIDTH product), 15 DIV (unsigned restoring)
- All adds/subtracts are computed at WIDTH+1 bits.
- Flag updates:
  - Carry = bit WIDTH on ADD/ADDC/ADDI.
  - Borrow = a < (b + borrow_in) on SUB/SUBB, and a < imm on SUBI.
  - SHL: carry = last bit shifted out. SHR: carry = last bit shifted out. Shift by 0 leaves carry unchanged.
  - MUL: carry = (product high ≠ 0).
  - Flags not named for an op are preserved.
  - Flags update only at completion (the `done_po` cycle).
- ADDC/SUBB use the flag value held at the cycle `start_pi` is accepted.
- DIV, b≠0: `result_po` = quotient, `result_hi_po` = remainder.
- DIV, b=0: quotient = all ones, remainder = a, `div_by_zero_po`=1, flags unchanged. Same latency as a normal DIV. `div_by_zero_po` clears on the next completion.
- `stc_pi`/`stb_pi` take effect only when `start_pi`=0 and `busy_po`=0. The flag reads 1 the next cycle. Both may be asserted together. Otherwise they are ignored.
- States:
  - IDLE: `start_pi` with op<14 → DONE; op 14/15 → RUN, iteration counter loaded with WIDTH.
  - RUN: one shift-add (MUL) or shift-subtract (DIV) step per cycle; counter decrements; reaching 0 → DONE.
  - DONE: `done_po`=1 for that cycle; `start_pi` accepted exactly as in IDLE; otherwise → IDLE.
- `start_pi` during RUN is ignored (not queued).
- Operands are captured at acceptance. Input changes afterwards do not affect the op in flight.
- Reset at any time, including mid-RUN: state→IDLE, in-flight op discarded, all outputs 0.

## Timing
- Reset values: `busy_po`, `done_po`, `result_po`, `result_hi_po`, `carry_po`, `borrow_po`, `div_by_zero_po` all 0.
- Single-cycle ops: accepted at edge T; results, flags and `done_po` valid in cycle T+1. Back-to-back issue gives one result per cycle.
- MUL/DIV: accepted at T; `busy_po`=1 in cycles T+1..T+WIDTH; `done_po` and results in cycle T+WIDTH+1. Latency is WIDTH+1.
- `result_po`/`result_hi_po` hold their value until the next completion.
- All outputs are registered. There are no combinational input→output paths.

## Test plan (WIDTH=16, IMM_W=6)
- Reset with `rst_n_pi`=0 for 2 cycles → all outputs 0. Then ADD 0xFFFF+0x0001 → `result_po`=0x0000, carry=1, `done_po` at T+1. Then ADDC 0x0001+0x0001 → 0x0003, carry=0.
- SUB 0x0003−0x0005 → 0xFFFE, borrow=1. Then SUBB 0x0005−0x0004 → 0x0000, borrow=0. Then `stb_pi` while idle → borrow=1 next cycle. Then SUBI a=0x0010, imm=0x3F → 0xFFD1, borrow=1.
- SHL a=0x8001, b=4 → 0x0010, carry=0. SHL a=0x1001, b=4 → 0x0010, carry=1. SHR a=0x0003, b=1 → 0x0001, carry=1. SHL b=0 → a unchanged, carry unchanged.
- MUL 0xFFFF×0xFFFF → hi=0xFFFE, lo=0x0001, carry=1, `busy_po` for 16 cycles, `done_po` at T+17. A `start_pi` issued mid-RUN is ignored.
- DIV 100/7 → quotient 14, remainder 2. DIV 0x1234/0 → quotient 0xFFFF, remainder 0x1234, `div_by_zero_po`=1 at T+17; the next ADD clears it.
- Reset asserted in the 8th RUN cycle of a MUL → outputs 0, state IDLE. A new ADD issued the cycle after reset release completes normally in 1 cycle.

Source files
------------

// File: rtl/seq_alu_if.sv
`timescale 1ns/1ps
// Issue/result bus between the decoder and the multi-cycle execute-stage ALU.
interface seq_alu_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned IMM_W = 6
);
   logic             start_pi;
   logic [3:0]       op_pi;
   logic [WIDTH-1:0] a_pi;
   logic [WIDTH-1:0] b_pi;
   logic [IMM_W-1:0] imm_pi;
   logic             stc_pi;
   logic             stb_pi;
   logic             busy_po;
   logic             done_po;
   logic [WIDTH-1:0] result_po;
   logic [WIDTH-1:0] result_hi_po;
   logic             carry_po;
   logic             borrow_po;
   logic             div_by_zero_po;

   modport master (
      output start_pi, op_pi, a_pi, b_pi, imm_pi, stc_pi, stb_pi,
      input  busy_po, done_po, result_po, result_hi_po, carry_po, borrow_po, div_by_zero_po
   );

   modport slave (
      input  start_pi, op_pi, a_pi, b_pi, imm_pi, stc_pi, stb_pi,
      output busy_po, done_po, result_po, result_hi_po, carry_po, borrow_po, div_by_zero_po
   );
endinterface

// File: rtl/seq_alu.sv
`timescale 1ns/1ps
// Multi-cycle execute-stage ALU: single-cycle logic/arith/shift ops plus
// iterative unsigned shift-add multiply and restoring divide.
module seq_alu #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned IMM_W = 6
) (
   input logic      clk_pi,
   input logic      rst_n_pi,
   seq_alu_if.slave bus
);
   localparam int unsigned XW    = WIDTH + 1;
   localparam int unsigned SH_W  = $clog2(WIDTH);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_ADDC = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_SUBB = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_XNOR = 4'd7;
   localparam logic [3:0] OP_NOT  = 4'd8;
   localparam logic [3:0] OP_SHL  = 4'd9;
   localparam logic [3:0] OP_SHR  = 4'd10;
   localparam logic [3:0] OP_CP   = 4'd11;
   localparam logic [3:0] OP_ADDI = 4'd12;
   localparam logic [3:0] OP_SUBI = 4'd13;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             is_div;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] opnd;
   logic             busy_q, done_q, carry_q, borrow_q, dbz_q;
   logic [WIDTH-1:0] res_q, res_hi_q;

   logic [XW-1:0]    a_ext_c, b_ext_c, i_ext_c, wide_c;
   logic [SH_W-1:0]  sh_c;
   logic [WIDTH-1:0] alu_res_c;
   logic             alu_carry_c, alu_borrow_c;

   logic [WIDTH-1:0] mul_add_c;
   logic [XW-1:0]    mul_sum_c;
   logic [XW-1:0]    div_sh_c;
   logic [WIDTH-1:0] div_diff_c;
   logic             div_ge_c;
   logic [WIDTH-1:0] hi_n_c, lo_n_c;

   assign bus.busy_po        = busy_q;
   assign bus.done_po        = done_q;
   assign bus.result_po      = res_q;
   assign bus.result_hi_po   = res_hi_q;
   assign bus.carry_po       = carry_q;
   assign bus.borrow_po      = borrow_q;
   assign bus.div_by_zero_po = dbz_q;

   // Single-cycle result and flags; flags not touched by an op keep their value.
   always_comb begin
      a_ext_c      = {1'b0, bus.a_pi};
      b_ext_c      = {1'b0, bus.b_pi};
      i_ext_c      = XW'(bus.imm_pi);
      sh_c         = bus.b_pi[SH_W-1:0];
      wide_c       = '0;
      alu_res_c    = '0;
      alu_carry_c  = carry_q;
      alu_borrow_c = borrow_q;
      case (bus.op_pi)
         OP_ADD: begin
            wide_c = a_ext_c + b_ext_c;
            alu_res_c = wide_c[WIDTH-1:0];
            alu_carry_c = wide_c[WIDTH];
         end
         OP_ADDC: begin
            wide_c = a_ext_c + b_ext_c + XW'(carry_q);
            alu_res_c = wide_c[WIDTH-1:0];
            alu_carry_c = wide_c[WIDTH];
         end
         OP_SUB: begin
            wide_c = a_ext_c - b_ext_c;
            alu_res_c = wide_c[WIDTH-1:0];
            alu_borrow_c = wide_c[WIDTH];
         end
         OP_SUBB: begin
            wide_c = a_ext_c - b_ext_c - XW'(borrow_q);
            alu_res_c = wide_c[WIDTH-1:0];
            alu_borrow_c = wide_c[WIDTH];
         end
         OP_AND:  alu_res_c = bus.a_pi & bus.b_pi;
         OP_OR:   alu_res_c = bus.a_pi | bus.b_pi;
         OP_XOR:  alu_res_c = bus.a_pi ^ bus.b_pi;
         OP_XNOR: alu_res_c = ~(bus.a_pi ^ bus.b_pi);
         OP_NOT:  alu_res_c = ~bus.a_pi;
         OP_SHL: begin
            // Extra top bit catches the last bit shifted out.
            wide_c = a_ext_c << sh_c;
            alu_res_c = wide_c[WIDTH-1:0];
            if (sh_c != '0) alu_carry_c = wide_c[WIDTH];
         end
         OP_SHR: begin
            // Extra bottom bit catches the last bit shifted out.
            wide_c = {bus.a_pi, 1'b0} >> sh_c;
            alu_res_c = wide_c[WIDTH:1];
            if (sh_c != '0) alu_carry_c = wide_c[0];
         end
         OP_CP:   alu_res_c = bus.a_pi;
         OP_ADDI: begin
            wide_c = a_ext_c + i_ext_c;
            alu_res_c = wide_c[WIDTH-1:0];
            alu_carry_c = wide_c[WIDTH];
         end
         OP_SUBI: begin
            wide_c = a_ext_c - i_ext_c;
            alu_res_c = wide_c[WIDTH-1:0];
            alu_borrow_c = wide_c[WIDTH];
         end
         default: alu_res_c = '0;
      endcase
   end

   // One multiply (shift-add) or divide (restoring shift-subtract) iteration.
   always_comb begin
      mul_add_c  = acc_lo[0] ? opnd : '0;
      mul_sum_c  = {1'b0, acc_hi} + {1'b0, mul_add_c};
      div_sh_c   = {acc_hi, acc_lo[WIDTH-1]};
      div_ge_c   = (div_sh_c >= {1'b0, opnd});
      div_diff_c = WIDTH'(div_sh_c - {1'b0, opnd});
      if (is_div) begin
         hi_n_c = div_ge_c ? div_diff_c : div_sh_c[WIDTH-1:0];
         lo_n_c = {acc_lo[WIDTH-2:0], div_ge_c};
      end else begin
         hi_n_c = mul_sum_c[WIDTH:1];
         lo_n_c = {mul_sum_c[0], acc_lo[WIDTH-1:1]};
      end
   end

   // Control FSM with registered results, flags and handshake.
   always_ff @(posedge clk_pi) begin
      if (!rst_n_pi) begin
         state    <= S_IDLE;
         cnt      <= '0;
         is_div   <= 1'b0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         res_q    <= '0;
         res_hi_q <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start_pi) begin
                  if (bus.op_pi[3:1] == 3'b111) begin
                     // MUL keeps multiplier in acc_lo; DIV keeps dividend there.
                     state  <= S_RUN;
                     busy_q <= 1'b1;
                     cnt    <= CNT_W'(WIDTH);
                     is_div <= bus.op_pi[0];
                     acc_hi <= '0;
                     acc_lo <= bus.op_pi[0] ? bus.a_pi : bus.b_pi;
                     opnd   <= bus.op_pi[0] ? bus.b_pi : bus.a_pi;
                  end else begin
                     state    <= S_DONE;
                     done_q   <= 1'b1;
                     res_q    <= alu_res_c;
                     res_hi_q <= '0;
                     carry_q  <= alu_carry_c;
                     borrow_q <= alu_borrow_c;
                     dbz_q    <= 1'b0;
                  end
               end else begin
                  state <= S_IDLE;
                  if (bus.stc_pi) carry_q <= 1'b1;
                  if (bus.stb_pi) borrow_q <= 1'b1;
               end
            end
            S_RUN: begin
               acc_hi <= hi_n_c;
               acc_lo <= lo_n_c;
               cnt    <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state    <= S_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  res_q    <= lo_n_c;
                  res_hi_q <= hi_n_c;
                  dbz_q    <= is_div && (opnd == '0);
                  if (!is_div) carry_q <= (hi_n_c != '0);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_alu.sv
`timescale 1ns/1ps
// Self-checking bench for seq_alu at WIDTH=16, IMM_W=6.
module tb_seq_alu;
   localparam int unsigned W  = 16;
   localparam int unsigned IW = 6;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_ADDC = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_SUBB = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_XNOR = 4'd7;
   localparam logic [3:0] OP_NOT  = 4'd8;
   localparam logic [3:0] OP_SHL  = 4'd9;
   localparam logic [3:0] OP_SHR  = 4'd10;
   localparam logic [3:0] OP_CP   = 4'd11;
   localparam logic [3:0] OP_ADDI = 4'd12;
   localparam logic [3:0] OP_SUBI = 4'd13;
   localparam logic [3:0] OP_MUL  = 4'd14;
   localparam logic [3:0] OP_DIV  = 4'd15;

   typedef struct packed {
      logic [15:0] res;
      logic [15:0] hi;
      logic        c;
      logic        bo;
      logic        dz;
   } out_t;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [5:0]  imm;
      out_t        exp;
      int          lat;
      string       name;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_pass  = 0;
   int   n_total = 0;
   out_t sb[$];
   logic m_c = 1'b0;
   logic m_b = 1'b0;

   seq_alu_if #(.WIDTH(W), .IMM_W(IW)) bus ();

   seq_alu #(.WIDTH(W), .IMM_W(IW)) dut (
      .clk_pi   (clk),
      .rst_n_pi (rst_n),
      .bus      (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic out_t cur_out();
      return {bus.result_po, bus.result_hi_po, bus.carry_po, bus.borrow_po, bus.div_by_zero_po};
   endfunction

   // Reference model for single-cycle ops, using the bench's own flag copies.
   function automatic out_t model(input logic [3:0] op, input logic [15:0] a,
                                  input logic [15:0] b, input logic [5:0] imm);
      int unsigned ua, ub, ui, sh, r;
      out_t o;
      ua = 32'(a); ub = 32'(b); ui = 32'(imm); sh = ub % 16; r = 0;
      o = '0; o.c = m_c; o.bo = m_b;
      case (op)
         OP_ADD:  begin r = ua + ub; o.c = (r > 32'hFFFF); end
         OP_ADDC: begin r = ua + ub + 32'(m_c); o.c = (r > 32'hFFFF); end
         OP_SUB:  begin r = ua - ub; o.bo = (ua < ub); end
         OP_SUBB: begin r = ua - ub - 32'(m_b); o.bo = (ua < ub + 32'(m_b)); end
         OP_AND:  r = ua & ub;
         OP_OR:   r = ua | ub;
         OP_XOR:  r = ua ^ ub;
         OP_XNOR: r = ~(ua ^ ub);
         OP_NOT:  r = ~ua;
         OP_SHL:  begin r = ua << sh; if (sh != 0) o.c = (((ua >> (16 - sh)) & 1) != 0); end
         OP_SHR:  begin r = ua >> sh; if (sh != 0) o.c = (((ua >> (sh - 1)) & 1) != 0); end
         OP_CP:   r = ua;
         OP_ADDI: begin r = ua + ui; o.c = (r > 32'hFFFF); end
         OP_SUBI: begin r = ua - ui; o.bo = (ua < ui); end
         default: r = 0;
      endcase
      o.res = 16'(r);
      return o;
   endfunction

   // Present one op for one edge, then scramble operands to prove capture.
   task automatic issue(input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [5:0] imm);
      bus.op_pi = op; bus.a_pi = a; bus.b_pi = b; bus.imm_pi = imm;
      bus.start_pi = 1'b1;
      @(negedge clk);
      bus.start_pi = 1'b0;
      bus.a_pi = 16'($urandom); bus.b_pi = 16'($urandom); bus.imm_pi = 6'($urandom);
   endtask

   // Cycles from acceptance until done_po; -1 if the budget expires.
   task automatic wait_done(input int budget, output int lat);
      lat = 1;
      while (bus.done_po !== 1'b1 && lat < budget) begin
         @(negedge clk);
         lat++;
      end
      if (bus.done_po !== 1'b1) lat = -1;
   endtask

   task automatic test_reset();
      logic [36:0] got;
      rst_n = 1'b0;
      bus.start_pi = 1'b0; bus.op_pi = '0; bus.a_pi = '0; bus.b_pi = '0;
      bus.imm_pi = '0; bus.stc_pi = 1'b0; bus.stb_pi = 1'b0;
      repeat (2) @(negedge clk);
      got = {bus.busy_po, bus.done_po, cur_out()};
      n_total++;
      if (got !== '0) $display("FAIL reset: got %h want 0", got);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_add_sub();
      vec_t v[5];
      int lat;
      out_t e, o;
      v[0] = '{OP_ADD,  16'hFFFF, 16'h0001, 6'd0,  {16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0}, 1, "add_carry"};
      v[1] = '{OP_ADDC, 16'h0001, 16'h0001, 6'd0,  {16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0}, 1, "addc"};
      v[2] = '{OP_SUB,  16'h0003, 16'h0005, 6'd0,  {16'hFFFE, 16'h0000, 1'b0, 1'b1, 1'b0}, 1, "sub_borrow"};
      v[3] = '{OP_SUBB, 16'h0005, 16'h0004, 6'd0,  {16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0}, 1, "subb"};
      v[4] = '{OP_SUBI, 16'h0010, 16'h0000, 6'h3F, {16'hFFD1, 16'h0000, 1'b0, 1'b1, 1'b0}, 1, "subi"};
      foreach (v[i]) begin
         if (i == 4) begin
            bus.stb_pi = 1'b1;
            @(negedge clk);
            bus.stb_pi = 1'b0;
            n_total++;
            if (bus.borrow_po !== 1'b1) $display("FAIL stb_idle: got borrow=%b want 1", bus.borrow_po);
            else n_pass++;
         end
         sb.push_back(v[i].exp);
         issue(v[i].op, v[i].a, v[i].b, v[i].imm);
         wait_done(40, lat);
         e = sb.pop_front();
         o = cur_out();
         n_total++;
         if (lat != v[i].lat || o !== e)
            $display("FAIL %s: got lat=%0d res=%h hi=%h c=%b b=%b dz=%b, want lat=%0d res=%h hi=%h c=%b b=%b dz=%b",
                     v[i].name, lat, o.res, o.hi, o.c, o.bo, o.dz, v[i].lat, e.res, e.hi, e.c, e.bo, e.dz);
         else n_pass++;
      end
   endtask

   task automatic test_shift();
      vec_t v[5];
      int lat;
      out_t e, o;
      v[0] = '{OP_SHL, 16'h8001, 16'h0004, 6'd0, {16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0}, 1, "shl_c0"};
      v[1] = '{OP_SHL, 16'h1001, 16'h0004, 6'd0, {16'h0010, 16'h0000, 1'b1, 1'b1, 1'b0}, 1, "shl_c1"};
      v[2] = '{OP_SHR, 16'h0003, 16'h0001, 6'd0, {16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0}, 1, "shr_c1"};
      v[3] = '{OP_SHL, 16'h8000, 16'h0010, 6'd0, {16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0}, 1, "shl_by0"};
      v[4] = '{OP_SHR, 16'h8000, 16'h000F, 6'd0, {16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0}, 1, "shr_by15"};
      foreach (v[i]) begin
         sb.push_back(v[i].exp);
         issue(v[i].op, v[i].a, v[i].b, v[i].imm);
         wait_done(40, lat);
         e = sb.pop_front();
         o = cur_out();
         n_total++;
         if (lat != v[i].lat || o !== e)
            $display("FAIL %s: got lat=%0d res=%h c=%b b=%b, want lat=%0d res=%h c=%b b=%b",
                     v[i].name, lat, o.res, o.c, o.bo, v[i].lat, e.res, e.c, e.bo);
         else n_pass++;
      end
   endtask

   task automatic test_mul();
      int lat, nbusy, extra;
      out_t e, o;
      sb.push_back({16'h0001, 16'hFFFE, 1'b1, 1'b1, 1'b0});
      issue(OP_MUL, 16'hFFFF, 16'hFFFF, 6'd0);
      lat = 1; nbusy = 0;
      while (bus.done_po !== 1'b1 && lat < 40) begin
         if (bus.busy_po === 1'b1) nbusy++;
         bus.op_pi = OP_ADD;
         bus.start_pi = (lat == 5);
         @(negedge clk);
         lat++;
      end
      bus.start_pi = 1'b0;
      if (bus.done_po !== 1'b1) lat = -1;
      e = sb.pop_front();
      o = cur_out();
      n_total++;
      if (lat != 17 || o !== e)
         $display("FAIL mul: got lat=%0d hi=%h lo=%h c=%b, want lat=17 hi=%h lo=%h c=%b",
                  lat, o.hi, o.res, o.c, e.hi, e.res, e.c);
      else n_pass++;
      n_total++;
      if (nbusy != 16) $display("FAIL mul_busy: got %0d busy cycles want 16", nbusy);
      else n_pass++;
      extra = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done_po === 1'b1) extra++;
      end
      n_total++;
      if (extra != 0) $display("FAIL mul_ignore_start: got %0d extra done pulses want 0", extra);
      else n_pass++;
   endtask

   task automatic test_div();
      vec_t v[3];
      int lat;
      out_t e, o;
      v[0] = '{OP_DIV, 16'd100,    16'd7,    6'd0, {16'd14,    16'd2,     1'b1, 1'b1, 1'b0}, 17, "div"};
      v[1] = '{OP_DIV, 16'h1234,   16'h0000, 6'd0, {16'hFFFF,  16'h1234,  1'b1, 1'b1, 1'b1}, 17, "div_by_zero"};
      v[2] = '{OP_ADD, 16'h0001,   16'h0001, 6'd0, {16'h0002,  16'h0000,  1'b0, 1'b1, 1'b0}, 1,  "dbz_clear"};
      foreach (v[i]) begin
         sb.push_back(v[i].exp);
         issue(v[i].op, v[i].a, v[i].b, v[i].imm);
         wait_done(40, lat);
         e = sb.pop_front();
         o = cur_out();
         n_total++;
         if (lat != v[i].lat || o !== e)
            $display("FAIL %s: got lat=%0d q=%h r=%h c=%b b=%b dz=%b, want lat=%0d q=%h r=%h c=%b b=%b dz=%b",
                     v[i].name, lat, o.res, o.hi, o.c, o.bo, o.dz, v[i].lat, e.res, e.hi, e.c, e.bo, e.dz);
         else n_pass++;
      end
   endtask

   task automatic test_set_flags();
      vec_t v[3];
      int lat;
      out_t e, o;
      v[0] = '{OP_SUB, 16'h0005, 16'h0003, 6'd0, {16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0}, 1, "sub_clear"};
      v[1] = '{OP_ADD, 16'h0001, 16'h0001, 6'd0, {16'h0002, 16'h0000, 1'b0, 1'b1, 1'b0}, 1, "add_clear_c"};
      v[2] = '{OP_AND, 16'hFFFF, 16'h00FF, 6'd0, {16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b0}, 1, "stc_with_start"};
      foreach (v[i]) begin
         if (i == 1) begin
            bus.stc_pi = 1'b1; bus.stb_pi = 1'b1;
            @(negedge clk);
            bus.stc_pi = 1'b0; bus.stb_pi = 1'b0;
            n_total++;
            if ({bus.carry_po, bus.borrow_po} !== 2'b11)
               $display("FAIL stc_stb: got c=%b b=%b want c=1 b=1", bus.carry_po, bus.borrow_po);
            else n_pass++;
         end
         sb.push_back(v[i].exp);
         bus.stc_pi = (i == 2);
         issue(v[i].op, v[i].a, v[i].b, v[i].imm);
         bus.stc_pi = 1'b0;
         wait_done(40, lat);
         e = sb.pop_front();
         o = cur_out();
         n_total++;
         if (lat != v[i].lat || o !== e)
            $display("FAIL %s: got lat=%0d res=%h c=%b b=%b, want lat=%0d res=%h c=%b b=%b",
                     v[i].name, lat, o.res, o.c, o.bo, v[i].lat, e.res, e.c, e.bo);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_run();
      logic [36:0] got;
      int lat;
      out_t e, o;
      issue(OP_MUL, 16'h0003, 16'h0005, 6'd0);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      got = {bus.busy_po, bus.done_po, cur_out()};
      n_total++;
      if (got !== '0) $display("FAIL reset_mid_run: got %h want 0", got);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      sb.push_back({16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0});
      issue(OP_ADD, 16'h0002, 16'h0003, 6'd0);
      wait_done(40, lat);
      e = sb.pop_front();
      o = cur_out();
      n_total++;
      if (lat != 1 || o !== e)
         $display("FAIL add_after_reset: got lat=%0d res=%h c=%b b=%b, want lat=1 res=%h c=%b b=%b",
                  lat, o.res, o.c, o.bo, e.res, e.c, e.bo);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      localparam int N = 10;
      logic [3:0]  op;
      logic [15:0] a, b;
      logic [5:0]  imm;
      out_t e, o;
      m_c = 1'b0; m_b = 1'b0;
      for (int k = 0; k <= N; k++) begin
         if (k > 0) begin
            o = cur_out();
            e = (sb.size() > 0) ? sb.pop_front() : '1;
            n_total++;
            if (bus.done_po !== 1'b1 || o !== e)
               $display("FAIL b2b_%0d: got done=%b res=%h hi=%h c=%b b=%b, want done=1 res=%h hi=%h c=%b b=%b",
                        k - 1, bus.done_po, o.res, o.hi, o.c, o.bo, e.res, e.hi, e.c, e.bo);
            else n_pass++;
         end
         if (k < N) begin
            op = 4'($urandom_range(13, 0)); a = 16'($urandom); b = 16'($urandom); imm = 6'($urandom);
            e = model(op, a, b, imm);
            m_c = e.c; m_b = e.bo;
            sb.push_back(e);
            bus.op_pi = op; bus.a_pi = a; bus.b_pi = b; bus.imm_pi = imm;
            bus.start_pi = 1'b1;
         end else begin
            bus.start_pi = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_shift();
      test_mul();
      test_div();
      test_set_flags();
      test_reset_mid_run();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 ns");
      $fatal(1);
   end
endmodule
